spwm_sequencer: RTL and testbench

SPWM_SEQUENCER -- requirements
Module: spwm_sequencer

---
 rtl/spwm_sequencer.sv | 160 ++++++++++++++++
 tb/tb_spwm_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spwm_sequencer.sv
// spwm_sequencer
//   Table-driven three-phase sinusoidal PWM sequencer. A 16-clock carrier is
//   compared against per-phase duty values fetched from an external table.
//   The table address advances every (div+1) carrier periods. Each phase
//   drives a complementary gate pair with dead time between the two sides.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    run request (level)
//   cfg_valid, cfg_div    divider offer (carrier periods per step, minus 1)
//   cfg_ready             divider offer can be accepted
//   rom_addr, rom_en      comparison-table address and enable
//   rom_d1..rom_d3        phase A/B/C duty values for rom_addr
//   pwm_{a,b,c}_{h,l}     complementary gate drives
//   period_start          pulse at carrier 0 of every RUN period
module spwm_sequencer #(
    parameter int unsigned TABLE_LAST  = 255,
    parameter int unsigned DEAD_CYCLES = 1,
    parameter logic [15:0] DIV_RESET   = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cfg_valid,
    input  logic [15:0] cfg_div,
    output logic        cfg_ready,
    output logic [15:0] rom_addr,
    output logic        rom_en,
    input  logic [3:0]  rom_d1,
    input  logic [3:0]  rom_d2,
    input  logic [3:0]  rom_d3,
    output logic        pwm_a_h,
    output logic        pwm_a_l,
    output logic        pwm_b_h,
    output logic        pwm_b_l,
    output logic        pwm_c_h,
    output logic        pwm_c_l,
    output logic        period_start
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Selects the most recent DEAD_CYCLES samples of each raw phase signal.
    localparam logic [2:0] HIST_MASK = 3'((1 << DEAD_CYCLES) - 1);

    state_t          state, state_next;
    logic [3:0]      carrier;
    logic [15:0]     step_cnt;
    logic [15:0]     div;
    logic [15:0]     pend;
    logic            pend_valid;
    logic [2:0][3:0] duty;
    logic [2:0][3:0] rom_d;
    logic [2:0]      r;
    logic [2:0][2:0] r_hist;
    logic [2:0]      pwm_h, pwm_l;
    logic            period_end;
    logic            step_bound;
    logic            duty_load;
    logic [15:0]     addr_inc;

    assign rom_d      = {rom_d3, rom_d2, rom_d1};
    assign period_end = (state != IDLE) && (carrier == 4'd15);
    assign step_bound = period_end && (step_cnt == div);
    // The first period after IDLE uses values captured on the start cycle.
    assign duty_load  = period_end || ((state == IDLE) && en);
    assign addr_inc   = (rom_addr == 16'(TABLE_LAST)) ? 16'd0 : rom_addr + 16'd1;

    assign cfg_ready    = ~pend_valid;
    assign rom_en       = (state != IDLE);
    assign period_start = (state == RUN) && (carrier == 4'd0);

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = DRAIN;
            DRAIN: begin
                if (en)                    state_next = RUN;
                else if (carrier == 4'd15) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[i] = (state != IDLE) && (carrier < duty[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            carrier    <= 4'd0;
            step_cnt   <= 16'd0;
            rom_addr   <= 16'd0;
            div        <= DIV_RESET;
            pend       <= 16'd0;
            pend_valid <= 1'b0;
            duty       <= '0;
        end else begin
            state   <= state_next;
            carrier <= (state == IDLE) ? 4'd0 : carrier + 4'd1;

            if (duty_load) duty <= rom_d;

            // Address and step count are kept through IDLE so a restart resumes in place.
            if (period_end) begin
                if (step_bound) begin
                    rom_addr <= addr_inc;
                    step_cnt <= 16'd0;
                end else begin
                    step_cnt <= step_cnt + 16'd1;
                end
            end

            // A value accepted on a boundary cycle is only seen as pending afterwards,
            // so it takes effect at the following boundary.
            if (pend_valid && (step_bound || state == IDLE)) begin
                div        <= pend;
                pend_valid <= 1'b0;
            end else if (cfg_valid && !pend_valid) begin
                pend       <= cfg_div;
                pend_valid <= 1'b1;
            end
        end
    end

    // A side turns on only once the raw signal has held its level for
    // DEAD_CYCLES+1 samples, and turns off as soon as it changes; pulses no
    // longer than the dead time never reach the gates. Both sides are off
    // whenever the next state is IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            pwm_h  <= '0;
            pwm_l  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_hist[i] <= {r_hist[i][1:0], r[i]};
                pwm_h[i]  <= (state_next != IDLE) && r[i]
                             && ((r_hist[i] & HIST_MASK) == HIST_MASK);
                pwm_l[i]  <= (state_next != IDLE) && !r[i]
                             && ((r_hist[i] & HIST_MASK) == 3'd0);
            end
        end
    end

    assign pwm_a_h = pwm_h[0];
    assign pwm_a_l = pwm_l[0];
    assign pwm_b_h = pwm_h[1];
    assign pwm_b_l = pwm_l[1];
    assign pwm_c_h = pwm_h[2];
    assign pwm_c_l = pwm_l[2];

endmodule

// File: tb/tb_spwm_sequencer.sv
// Testbench for spwm_sequencer: directed scenarios plus randomized run,
// checked every cycle against a behavioural model of the sequencer.
module tb_spwm_sequencer;

    localparam int DEAD = 1;
    localparam int LAST = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = 16'd0;
    logic        cfg_ready;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic [3:0]  rom_d1, rom_d2, rom_d3;
    logic        pwm_a_h, pwm_a_l, pwm_b_h, pwm_b_l, pwm_c_h, pwm_c_l;
    logic        period_start;

    int checks = 0;
    int failures = 0;

    // Comparison table: random contents or constant per-phase values.
    logic [3:0] tab [3][256];
    logic [3:0] cd [3];
    logic       rom_mode = 1'b0;

    assign rom_d1 = rom_mode ? cd[0] : tab[0][rom_addr[7:0]];
    assign rom_d2 = rom_mode ? cd[1] : tab[1][rom_addr[7:0]];
    assign rom_d3 = rom_mode ? cd[2] : tab[2][rom_addr[7:0]];

    always #5 clk = ~clk;

    spwm_sequencer #(
        .TABLE_LAST (LAST),
        .DEAD_CYCLES(DEAD),
        .DIV_RESET  (16'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .rom_addr    (rom_addr),
        .rom_en      (rom_en),
        .rom_d1      (rom_d1),
        .rom_d2      (rom_d2),
        .rom_d3      (rom_d3),
        .pwm_a_h     (pwm_a_h),
        .pwm_a_l     (pwm_a_l),
        .pwm_b_h     (pwm_b_h),
        .pwm_b_l     (pwm_b_l),
        .pwm_c_h     (pwm_c_h),
        .pwm_c_l     (pwm_c_l),
        .period_start(period_start)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 run, 2 drain. Dead time is modelled by how long each
    // raw phase signal has held its present level.
    int m_st, m_car, m_step, m_addr, m_div, m_pend;
    int m_duty [3];
    int m_len  [3];
    bit m_pend_v;
    bit m_prev [3];
    bit m_h    [3];
    bit m_l    [3];

    function automatic int rom_val(int ph, int a);
        if (rom_mode) return int'(cd[ph]);
        return int'(tab[ph][a % 256]);
    endfunction

    task automatic model_reset();
        m_st = 0; m_car = 0; m_step = 0; m_addr = 0; m_div = 0;
        m_pend = 0; m_pend_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_duty[i] = 0; m_len[i] = 16; m_prev[i] = 1'b0;
            m_h[i] = 1'b0; m_l[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int nst;
        bit bnd;
        bit old_pv;
        bit r [3];
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) r[i] = (m_st != 0) && (m_car < m_duty[i]);
        case (m_st)
            0:       nst = en ? 1 : 0;
            1:       nst = en ? 1 : 2;
            default: nst = en ? 1 : ((m_car == 15) ? 0 : 2);
        endcase
        bnd = 1'b0;
        if (m_st != 0 && m_car == 15) begin
            for (int i = 0; i < 3; i++) m_duty[i] = rom_val(i, m_addr);
            if (m_step == m_div) begin
                m_addr = (m_addr == LAST) ? 0 : m_addr + 1;
                m_step = 0;
                bnd = 1'b1;
            end else begin
                m_step = m_step + 1;
            end
        end
        if (m_st == 0 && en) for (int i = 0; i < 3; i++) m_duty[i] = rom_val(i, m_addr);
        old_pv = m_pend_v;
        if (old_pv && (bnd || m_st == 0)) begin
            m_div = m_pend;
            m_pend_v = 1'b0;
        end
        if (!old_pv && cfg_valid) begin
            m_pend = int'(cfg_div);
            m_pend_v = 1'b1;
        end
        m_car = (m_st == 0) ? 0 : (m_car + 1) % 16;
        for (int i = 0; i < 3; i++) begin
            if (r[i] == m_prev[i]) m_len[i] = (m_len[i] < 16) ? m_len[i] + 1 : 16;
            else begin
                m_prev[i] = r[i];
                m_len[i] = 1;
            end
            m_h[i] = (nst != 0) && m_prev[i] && (m_len[i] > DEAD);
            m_l[i] = (nst != 0) && !m_prev[i] && (m_len[i] > DEAD);
        end
        m_st = nst;
    endtask

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        check("rom_addr", int'(rom_addr), m_addr);
        check("rom_en", int'(rom_en), int'(m_st != 0));
        check("period_start", int'(period_start), int'(m_st == 1 && m_car == 0));
        check("cfg_ready", int'(cfg_ready), int'(!m_pend_v));
        check("pwm_a_h", int'(pwm_a_h), int'(m_h[0]));
        check("pwm_a_l", int'(pwm_a_l), int'(m_l[0]));
        check("pwm_b_h", int'(pwm_b_h), int'(m_h[1]));
        check("pwm_b_l", int'(pwm_b_l), int'(m_l[1]));
        check("pwm_c_h", int'(pwm_c_h), int'(m_h[2]));
        check("pwm_c_l", int'(pwm_c_l), int'(m_l[2]));
        check("overlap_a", int'(pwm_a_h & pwm_a_l), 0);
        check("overlap_b", int'(pwm_b_h & pwm_b_l), 0);
        check("overlap_c", int'(pwm_c_h & pwm_c_l), 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wait_ps(input string name);
        int k;
        k = 0;
        while (period_start !== 1'b1 && k < 100) begin
            cycle();
            k++;
        end
        if (k >= 100) check({name, "_timeout"}, 0, 1);
    endtask

    // Cycles between two consecutive rom_addr changes.
    task automatic measure_interval(output int iv);
        logic [15:0] a0;
        int k;
        a0 = rom_addr;
        k = 0;
        while (rom_addr == a0 && k < 300) begin
            cycle();
            k++;
        end
        a0 = rom_addr;
        iv = 0;
        while (rom_addr == a0 && iv < 300) begin
            cycle();
            iv++;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_rom_en", int'(rom_en), 0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_pwm", int'({pwm_a_h, pwm_a_l, pwm_b_h, pwm_b_l, pwm_c_h, pwm_c_l}), 0);
        cycles(2);
        rst_n = 1'b1;
    endtask

    int cnt_h [3];
    int cnt_ps;
    int iv;
    logic [15:0] a_hold;

    initial begin
        for (int p = 0; p < 3; p++)
            for (int a = 0; a < 256; a++) tab[p][a] = 4'($urandom_range(0, 15));
        cd[0] = 4'd8; cd[1] = 4'd8; cd[2] = 4'd8;
        rom_mode = 1'b1;
        model_reset();
        #1;
        pulse_reset();
        cycles(3);
        check("idle_pwm_a_l", int'(pwm_a_l), 0);
        check("idle_rom_addr", int'(rom_addr), 0);

        // Constant duty 8, div 0.
        en = 1'b1;
        cycle();
        check("first_run_period_start", int'(period_start), 1);
        for (int i = 0; i < 3; i++) cnt_h[i] = 0;
        cnt_ps = 0;
        for (int k = 0; k < 16; k++) begin
            cnt_h[0] += int'(pwm_a_h);
            cnt_ps   += int'(period_start);
            cycle();
        end
        check("duty8_high_count", cnt_h[0], 8 - DEAD);
        check("period_start_per_16", cnt_ps, 1);
        check("addr_after_one_period", int'(rom_addr), 1);
        measure_interval(iv);
        check("step_interval_div0", iv, 16);

        // Address wrap.
        begin
            int k;
            k = 0;
            while (rom_addr != 16'd255 && k < 5000) begin
                cycle();
                k++;
            end
            check("reach_addr_255", int'(rom_addr), 255);
            k = 0;
            while (rom_addr == 16'd255 && k < 40) begin
                cycle();
                k++;
            end
            check("wrap_to_zero", int'(rom_addr), 0);
        end

        // Divider change mid-period, second offer ignored.
        wait_ps("cfg_sync");
        cycles(3);
        cfg_valid = 1'b1; cfg_div = 16'd2;
        cycle();
        cfg_valid = 1'b1; cfg_div = 16'd7;
        check("cfg_ready_low_after_transfer", int'(cfg_ready), 0);
        cycle();
        cfg_valid = 1'b0;
        measure_interval(iv);
        measure_interval(iv);
        check("step_interval_div2", iv, 48);
        check("cfg_ready_restored", int'(cfg_ready), 1);
        cfg_valid = 1'b1; cfg_div = 16'd0;
        cycle();
        cfg_valid = 1'b0;
        measure_interval(iv);

        // en dropped at carrier 5: drain then idle, address held, resume.
        wait_ps("drain_sync");
        cycles(5);
        en = 1'b0;
        cycles(11);
        check("drain_to_idle_rom_en", int'(rom_en), 0);
        check("idle_outputs_zero", int'({pwm_a_h, pwm_a_l, pwm_b_h, pwm_b_l, pwm_c_h, pwm_c_l}), 0);
        a_hold = rom_addr;
        cycles(20);
        check("idle_addr_held", int'(rom_addr), int'(a_hold));
        en = 1'b1;
        cycle();
        check("resume_addr", int'(rom_addr), int'(a_hold));
        check("resume_period_start", int'(period_start), 1);

        // Duty 0, 1, 15.
        cd[0] = 4'd0; cd[1] = 4'd1; cd[2] = 4'd15;
        cycles(40);
        wait_ps("duty_sync");
        for (int i = 0; i < 3; i++) cnt_h[i] = 0;
        for (int k = 0; k < 16; k++) begin
            cnt_h[0] += int'(pwm_a_h);
            cnt_h[1] += int'(pwm_b_h);
            cnt_h[2] += int'(pwm_c_h);
            cycle();
        end
        check("duty0_high_count", cnt_h[0], 0);
        check("duty1_suppressed", cnt_h[1], 0);
        check("duty15_high_count", cnt_h[2], 15 - DEAD);

        // Reset at carrier 9 with a pending divider.
        cd[0] = 4'd8; cd[1] = 4'd8; cd[2] = 4'd8;
        wait_ps("reset_sync");
        cycle();
        cfg_valid = 1'b1; cfg_div = 16'd3;
        cycle();
        cfg_valid = 1'b0;
        cycles(7);
        check("pending_before_reset", int'(cfg_ready), 0);
        pulse_reset();
        measure_interval(iv);
        check("div_reset_interval", iv, 16);

        // Randomized run.
        rom_mode = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_div = 16'($urandom_range(0, 3));
            if (k == 3000) pulse_reset();
            else cycle();
        end
        cfg_valid = 1'b0;
        en = 1'b0;
        cycles(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
